// File: rtl/axi_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_queue_pkg
// Brief    : Shared AXI4 Ax-channel field widths, beat type and sizing helpers.
// Revision : 1.0
// ============================================================================
package axi_queue_pkg;

    localparam int unsigned AXI_ADDR_W   = 32;
    localparam int unsigned AXI_ID_W     = 6;
    localparam int unsigned AXI_USER_W   = 1;
    localparam int unsigned AXI_LEN_W    = 8;
    localparam int unsigned AXI_SIZE_W   = 3;
    localparam int unsigned AXI_BURST_W  = 2;
    localparam int unsigned AXI_LOCK_W   = 1;
    localparam int unsigned AXI_CACHE_W  = 4;
    localparam int unsigned AXI_PROT_W   = 3;
    localparam int unsigned AXI_QOS_W    = 4;
    localparam int unsigned AXI_REGION_W = 4;

    typedef struct packed {
        logic [AXI_ADDR_W-1:0]   addr;
        logic [AXI_LEN_W-1:0]    len;
        logic [AXI_SIZE_W-1:0]   size;
        logic [AXI_BURST_W-1:0]  burst;
        logic [AXI_LOCK_W-1:0]   lock;
        logic [AXI_CACHE_W-1:0]  cache;
        logic [AXI_PROT_W-1:0]   prot;
        logic [AXI_QOS_W-1:0]    qos;
        logic [AXI_REGION_W-1:0] region;
        logic [AXI_ID_W-1:0]     id;
        logic [AXI_USER_W-1:0]   user;
    } axi_ax_t;

    // Width of one packed Ax beat for a given address/ID/user configuration.
    function automatic int unsigned ax_beat_w(input int unsigned addr_w,
                                              input int unsigned id_w,
                                              input int unsigned user_w);
        return addr_w + AXI_LEN_W + AXI_SIZE_W + AXI_BURST_W + AXI_LOCK_W
             + AXI_CACHE_W + AXI_PROT_W + AXI_QOS_W + AXI_REGION_W + id_w + user_w;
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_queue_ptr.sv
`default_nettype none
// ============================================================================
// Module   : axi_queue_ptr
// Brief    : Incrementing queue pointer with enable, wrapping from DEPTH-1 to 0.
// Revision : 1.0
// ============================================================================
module axi_queue_ptr
    import axi_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Explicit wrap keeps non-power-of-two depths inside [0, DEPTH-1].
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/axi_addr_queue.sv
`default_nettype none
// ============================================================================
// Module   : axi_addr_queue
// Brief    : Parametrised AXI4 AR/AW address-channel FIFO with occupancy count,
//            optional empty-queue flow-through and full-queue pipe modes.
// Revision : 1.0
// ============================================================================
module axi_addr_queue
    import axi_queue_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned ID_W   = 6,
    parameter  int unsigned USER_W = 1,
    parameter  bit          FLOW   = 1'b0,
    parameter  bit          PIPE   = 1'b0,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,

    input  logic                    io_enq_valid,
    output logic                    io_enq_ready,
    input  logic [ADDR_W-1:0]       io_enq_bits_addr,
    input  logic [AXI_LEN_W-1:0]    io_enq_bits_len,
    input  logic [AXI_SIZE_W-1:0]   io_enq_bits_size,
    input  logic [AXI_BURST_W-1:0]  io_enq_bits_burst,
    input  logic                    io_enq_bits_lock,
    input  logic [AXI_CACHE_W-1:0]  io_enq_bits_cache,
    input  logic [AXI_PROT_W-1:0]   io_enq_bits_prot,
    input  logic [AXI_QOS_W-1:0]    io_enq_bits_qos,
    input  logic [AXI_REGION_W-1:0] io_enq_bits_region,
    input  logic [ID_W-1:0]         io_enq_bits_id,
    input  logic [USER_W-1:0]       io_enq_bits_user,

    output logic                    io_deq_valid,
    input  logic                    io_deq_ready,
    output logic [ADDR_W-1:0]       io_deq_bits_addr,
    output logic [AXI_LEN_W-1:0]    io_deq_bits_len,
    output logic [AXI_SIZE_W-1:0]   io_deq_bits_size,
    output logic [AXI_BURST_W-1:0]  io_deq_bits_burst,
    output logic                    io_deq_bits_lock,
    output logic [AXI_CACHE_W-1:0]  io_deq_bits_cache,
    output logic [AXI_PROT_W-1:0]   io_deq_bits_prot,
    output logic [AXI_QOS_W-1:0]    io_deq_bits_qos,
    output logic [AXI_REGION_W-1:0] io_deq_bits_region,
    output logic [ID_W-1:0]         io_deq_bits_id,
    output logic [USER_W-1:0]       io_deq_bits_user,

    output logic [CNT_W-1:0]        io_count
);

    localparam int unsigned PTR_W  = ptr_w(DEPTH);
    localparam int unsigned BEAT_W = ax_beat_w(ADDR_W, ID_W, USER_W);

    logic [BEAT_W-1:0] mem_q [DEPTH];
    logic              maybe_full_q;
    logic              maybe_full_d;

    logic [PTR_W-1:0]  enq_ptr;
    logic [PTR_W-1:0]  deq_ptr;
    logic [BEAT_W-1:0] enq_beat;
    logic [BEAT_W-1:0] head_beat;
    logic [BEAT_W-1:0] deq_beat;

    logic ptr_match;
    logic empty;
    logic full;
    logic bypass;
    logic do_enq;
    logic do_deq;
    logic wr_en;
    logic rd_adv;

    logic [CNT_W-1:0] enq_ext;
    logic [CNT_W-1:0] deq_ext;
    logic [CNT_W-1:0] count;

    assign enq_beat = {io_enq_bits_addr, io_enq_bits_len, io_enq_bits_size,
                       io_enq_bits_burst, io_enq_bits_lock, io_enq_bits_cache,
                       io_enq_bits_prot, io_enq_bits_qos, io_enq_bits_region,
                       io_enq_bits_id, io_enq_bits_user};

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full_q;
    assign full      = ptr_match &  maybe_full_q;

    assign io_enq_ready = ~full | (PIPE & io_deq_ready);
    assign bypass       = FLOW & empty & io_enq_valid;
    assign io_deq_valid = ~empty | bypass;

    assign do_enq = io_enq_valid & io_enq_ready;
    assign do_deq = io_deq_valid & io_deq_ready;

    // A bypassed beat consumed in the same cycle never touches storage.
    assign wr_en  = do_enq & ~(bypass & io_deq_ready);
    assign rd_adv = do_deq & ~bypass;

    always_comb begin
        maybe_full_d = maybe_full_q;
        if (wr_en != rd_adv) begin
            maybe_full_d = wr_en;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            maybe_full_q <= 1'b0;
        end else begin
            maybe_full_q <= maybe_full_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[enq_ptr] <= enq_beat;
        end
    end

    axi_queue_ptr #(
        .DEPTH   (DEPTH)
    ) u_enq_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (wr_en),
        .ptr_o   (enq_ptr)
    );

    axi_queue_ptr #(
        .DEPTH   (DEPTH)
    ) u_deq_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (rd_adv),
        .ptr_o   (deq_ptr)
    );

    // Occupancy is widened to CNT_W before subtracting so DEPTH itself is representable.
    assign enq_ext = CNT_W'(enq_ptr);
    assign deq_ext = CNT_W'(deq_ptr);

    always_comb begin
        count = '0;
        if (full) begin
            count = CNT_W'(DEPTH);
        end else if (enq_ext >= deq_ext) begin
            count = enq_ext - deq_ext;
        end else begin
            count = CNT_W'(DEPTH) - deq_ext + enq_ext;
        end
    end

    assign io_count  = count;
    assign head_beat = mem_q[deq_ptr];
    assign deq_beat  = bypass ? enq_beat : head_beat;

    assign {io_deq_bits_addr, io_deq_bits_len, io_deq_bits_size,
            io_deq_bits_burst, io_deq_bits_lock, io_deq_bits_cache,
            io_deq_bits_prot, io_deq_bits_qos, io_deq_bits_region,
            io_deq_bits_id, io_deq_bits_user} = deq_beat;

endmodule
`default_nettype wire

// File: tb/tb_axi_addr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_addr_queue
// Brief    : Scoreboard bench driving several queue configurations in parallel
//            against a behavioural queue model.
// Revision : 1.0
// ============================================================================
module tb_axi_addr_queue;

    localparam int NDUT = 5;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  id;
        logic        user;
    } beat_t;

    // Configurations: {DEPTH, FLOW, PIPE}
    function automatic int unsigned cfg_depth(input int g);
        case (g)
            0: return 4;
            1: return 3;
            2: return 4;
            3: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit cfg_flow(input int g);
        return (g == 3);
    endfunction

    function automatic bit cfg_pipe(input int g);
        return (g == 2);
    endfunction

    logic  clk = 1'b0;
    logic  reset_n = 1'b0;
    logic  enq_valid = 1'b0;
    logic  deq_ready = 1'b0;
    beat_t enq = '0;

    bit    mon_en = 1'b0;
    bit    chk_zero = 1'b0;
    int    checks = 0;
    int    failures = 0;

    logic [6:0] cnt_all [NDUT];
    logic       vld_all [NDUT];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t: got 0x%0h expected 0x%0h", nm, d, $time, act, exp);
        end
    endtask

    function automatic beat_t rand_beat();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[67:0];
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned D  = cfg_depth(g);
        localparam bit          F  = cfg_flow(g);
        localparam bit          P  = cfg_pipe(g);
        localparam int unsigned CW = $clog2(D + 1);

        logic          w_enq_ready;
        logic          w_deq_valid;
        logic [CW-1:0] w_cnt;
        beat_t         w_deq;

        axi_addr_queue #(
            .DEPTH (D), .ADDR_W(32), .ID_W(6), .USER_W(1), .FLOW(F), .PIPE(P)
        ) u_dut (
            .clk                (clk),
            .reset_n            (reset_n),
            .io_enq_valid       (enq_valid),
            .io_enq_ready       (w_enq_ready),
            .io_enq_bits_addr   (enq.addr),
            .io_enq_bits_len    (enq.len),
            .io_enq_bits_size   (enq.size),
            .io_enq_bits_burst  (enq.burst),
            .io_enq_bits_lock   (enq.lock),
            .io_enq_bits_cache  (enq.cache),
            .io_enq_bits_prot   (enq.prot),
            .io_enq_bits_qos    (enq.qos),
            .io_enq_bits_region (enq.region),
            .io_enq_bits_id     (enq.id),
            .io_enq_bits_user   (enq.user),
            .io_deq_valid       (w_deq_valid),
            .io_deq_ready       (deq_ready),
            .io_deq_bits_addr   (w_deq.addr),
            .io_deq_bits_len    (w_deq.len),
            .io_deq_bits_size   (w_deq.size),
            .io_deq_bits_burst  (w_deq.burst),
            .io_deq_bits_lock   (w_deq.lock),
            .io_deq_bits_cache  (w_deq.cache),
            .io_deq_bits_prot   (w_deq.prot),
            .io_deq_bits_qos    (w_deq.qos),
            .io_deq_bits_region (w_deq.region),
            .io_deq_bits_id     (w_deq.id),
            .io_deq_bits_user   (w_deq.user),
            .io_count           (w_cnt)
        );

        assign cnt_all[g] = 7'(w_cnt);
        assign vld_all[g] = w_deq_valid;

        // Expected contents of the queue, oldest first.
        beat_t sb[$];

        always @(negedge clk or negedge reset_n) begin
            int unsigned n;
            bit          byp;
            bit          exp_vld;
            bit          exp_rdy;
            beat_t       exp_head;
            if (!reset_n) begin
                sb.delete();
            end else if (mon_en) begin
                n        = sb.size();
                exp_rdy  = (n < D) || (P && deq_ready);
                byp      = F && (n == 0) && enq_valid;
                exp_vld  = (n > 0) || byp;
                exp_head = '0;
                if (byp)        exp_head = enq;
                else if (n > 0) exp_head = sb[0];

                chk("count", g, w_cnt, n);
                chk("enq_ready", g, w_enq_ready, exp_rdy);
                chk("deq_valid", g, w_deq_valid, exp_vld);
                if (chk_zero) chk("deq_bits_after_reset", g, w_deq, 0);
                if (w_deq_valid && exp_vld) chk("deq_bits", g, w_deq, exp_head);

                if (!(byp && deq_ready)) begin
                    if (exp_vld && deq_ready) void'(sb.pop_front());
                    if (enq_valid && exp_rdy) sb.push_back(enq);
                end
            end
        end
    end

    task automatic step(input bit ev, input bit dr, input beat_t b);
        enq_valid = ev;
        deq_ready = dr;
        enq       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mon_en   = 1'b1;
        chk_zero = 1'b1;
        step(1'b0, 1'b0, rand_beat());
        chk_zero = 1'b0;
    endtask

    initial begin
        beat_t b;
        int unsigned pe;
        int unsigned pd;

        repeat (3) @(posedge clk);
        release_reset();

        // Fill past capacity with the consumer stalled, then drain.
        for (int i = 0; i < 6; i++) begin
            b = rand_beat();
            b.addr = 32'h10 * (i + 1);
            step(1'b1, 1'b0, b);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, rand_beat());
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rand_beat());

        // Continuous streaming with incrementing IDs.
        for (int i = 0; i < 10; i++) begin
            b = rand_beat();
            b.id = 6'(i);
            step(1'b1, 1'b1, b);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rand_beat());

        // Flow-through on an empty queue with a specific address.
        b = rand_beat();
        b.addr = 32'hABCD;
        step(1'b1, 1'b1, b);

        // Randomized traffic with changing pressure on each side.
        for (int blk = 0; blk < 15; blk++) begin
            pe = $urandom_range(95, 5);
            pd = $urandom_range(95, 5);
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(99, 0) < pe, $urandom_range(99, 0) < pd, rand_beat());
            end
        end

        // Asynchronous reset in the middle of a cycle with entries held.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rand_beat());
        step(1'b1, 1'b0, rand_beat());
        step(1'b1, 1'b0, rand_beat());
        enq_valid = 1'b0;
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk("async_reset_count", k, cnt_all[k], 0);
            chk("async_reset_valid", k, vld_all[k], 0);
        end
        release_reset();
        for (int c = 0; c < 100; c++) begin
            step($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, rand_beat());
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_addr_queue.md
# axi_addr_queue

Parametrised AXI4 address-channel (AR/AW) FIFO for the coyote interconnect. It is the successor to the single-entry address queue, with configurable depth, configurable ID/address/user widths, an occupancy count, and optional flow-through and pipe modes. It sits between an AXI master port and the crossbar/arbiter to decouple address-channel backpressure.

## Interface
- DEPTH, 4, number of entries; 1..64, any integer (not restricted to powers of two)
- ADDR_W, 32, address width
- ID_W, 6, transaction ID width
- USER_W, 1, user sideband width
- FLOW, 0, 1 = empty-queue bypass: enq data appears on deq in the same cycle
- PIPE, 0, 1 = enq_ready also asserted when full and deq_ready=1
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- io_enq_valid  in  1  enqueue request
- io_enq_ready  out  1  queue can accept
- io_enq_bits_{addr,len,size,burst,lock,cache,prot,qos,region,id,user}  in  ADDR_W,8,3,2,1,4,3,4,4,ID_W,USER_W  AXI Ax beat
- io_deq_valid  out  1  head entry valid
- io_deq_ready  in  1  consumer accepts
- io_deq_bits_{same fields}  out  same widths  head entry
- io_count  out  CNT_W=$clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry register array of the packed Ax beat; enq_ptr, deq_ptr in [0, DEPTH-1]; maybe_full flag.
- Pointers wrap explicitly from DEPTH-1 to 0. Do not rely on natural binary overflow.
- ptr_match = (enq_ptr == deq_ptr); empty = ptr_match & ~maybe_full; full = ptr_match & maybe_full.
- do_enq = io_enq_valid & io_enq_ready; do_deq = io_deq_valid & io_deq_ready.
- do_enq: write the entry at enq_ptr, then advance enq_ptr. do_deq: advance deq_ptr.
- maybe_full <= do_enq when do_enq != do_deq; otherwise it holds.
- io_enq_ready = ~full, or (PIPE & io_deq_ready) when full.
- io_deq_valid = ~empty, or (FLOW & io_enq_valid) when empty.
- FLOW bypass (empty & io_enq_valid): io_deq_bits = io_enq_bits. If io_deq_ready, nothing is written and no pointer moves.
- io_count = full ? DEPTH : (enq_ptr - deq_ptr) mod DEPTH, computed without truncation to log2(DEPTH) bits.
- Simultaneous enq+deq when not empty and not full: both pointers advance, count unchanged.
- Simultaneous enq+deq when full with PIPE=0: only deq occurs, because enq_ready=0.
- Simultaneous enq+deq when full with PIPE=1: both occur, and the written slot is the one being freed.
- DEPTH=1: pointers are constant 0; the block behaves as the legacy single-entry queue with io_count 0/1.

## Timing
- Reset (reset_n low, asynchronous assert, synchronous deassert by the reset tree):
  - ptrs=0, maybe_full=0, storage=0
  - io_enq_ready=1, io_deq_valid=0 (FLOW=0), io_count=0, io_deq_bits=0
- Reset asserted mid-operation discards all entries immediately, with no flush handshake.
- Latency enq→deq is 1 cycle (FLOW=0) or 0 cycles (FLOW=1, empty).
- Registered outputs: io_count and io_deq_bits in non-bypass mode are pure functions of state.
- Combinational paths:
  - io_enq_ready depends on io_deq_ready only when PIPE=1.
  - io_deq_valid/bits depend on io_enq_* only when FLOW=1.
- Valid/ready is AXI-compliant: the queue never drops io_deq_valid without a handshake, and head data is stable while io_deq_valid & ~io_deq_ready.

## Structure
- Package axi_queue_pkg holds:
  - axi_ax_t packed struct, parametrised via localparams ADDR_W/ID_W/USER_W defaults
  - AXI_LEN_W=8, AXI_SIZE_W=3, AXI_BURST_W=2, AXI_CACHE_W=4, AXI_PROT_W=3, AXI_QOS_W=4, AXI_REGION_W=4
- One sub-module: axi_queue_ptr, a wrap-at-DEPTH-1 incrementing pointer with enable, instantiated twice.

## Test plan
- Reset then idle: io_enq_ready=1, io_deq_valid=0, io_count=0, io_deq_bits_addr=0.
- DEPTH=4, enqueue addr 0x10,0x20,0x30,0x40 with io_deq_ready=0:
  - io_count steps 1..4, io_enq_ready=0 after the 4th
  - a 5th io_enq_valid is not accepted
  - drain yields 0x10..0x40 in order
- DEPTH=3 (non-power-of-two), 10 continuous enq+deq cycles with incrementing ids: output ids match in order and io_count stays at 1 throughout.
- Full DEPTH=4, io_enq_valid=1, io_deq_ready=1:
  - PIPE=0: count goes 4→3, enq not accepted
  - PIPE=1: count stays 4, new beat appears after the 4 older ones
- FLOW=1, empty, io_enq_valid=1, addr=0xABCD, io_deq_ready=1: io_deq_valid=1 and io_deq_bits_addr=0xABCD in the same cycle, and io_count stays 0.
- Fill 2 entries, pulse reset_n low mid-cycle: io_count=0 and io_deq_valid=0 immediately, without waiting for a clock edge.
